// File: rtl/seg_pkg.sv
// Shared constants for the scanned BCD display: segment codes, converter
// state encoding, digit-select one-hots and the BCD digit payload.
package seg_pkg;

  localparam int unsigned BIN_W   = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SHIFT_W = 4;
  localparam int unsigned BIN_BITS = 8;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low one-hot digit enables
  localparam logic [3:0] SEL_NONE = 4'b1111;
  localparam logic [3:0] SEL_D0   = 4'b0111;
  localparam logic [3:0] SEL_D1   = 4'b1011;
  localparam logic [3:0] SEL_D2   = 4'b1101;
  localparam logic [3:0] SEL_D3   = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } conv_state_e;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // BCD digit to segment pattern; non-decimal nibbles show blank
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Digit index to active-low select
  function automatic logic [3:0] sel_code(input logic [1:0] idx);
    logic [3:0] s;
    case (idx)
      2'd0:    s = SEL_D0;
      2'd1:    s = SEL_D1;
      2'd2:    s = SEL_D2;
      default: s = SEL_D3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble converter.
//   clk, rst_n : clock, async active-low reset
//   start      : capture bin, clear accumulator, begin 8 shift steps
//   bin        : binary input (sampled only on start)
//   done       : high during the final shift step; bcd is complete next cycle
//   bcd        : {hundreds, tens, ones}
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output bcd_t             bcd
);

  logic [BIN_W-1:0]   sh;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj_c;
  logic [SHIFT_W-1:0] cnt;

  // Add 3 to every nibble >= 5 before the shift
  always_comb begin
    acc_adj_c = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shadow shift register, accumulator and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= SHIFT_W'(BIN_BITS);
      done <= 1'b0;
    end else if (cnt != '0) begin
      acc  <= {acc_adj_c[BCD_W-2:0], sh[BIN_W-1]};
      sh   <= {sh[BIN_W-2:0], 1'b0};
      cnt  <= cnt - SHIFT_W'(1);
      done <= (cnt == SHIFT_W'(2));
    end else begin
      done <= 1'b0;
    end
  end

  assign bcd = bcd_t'(acc);

endmodule

// File: rtl/seg_scan_bcd.sv
// 4-digit common-anode 7-segment scanner with per-frame BCD conversion.
//   clk, rst_n : clock, async active-low reset
//   dat1       : left pair value (sel[3] tens, sel[2] ones)
//   dat2       : right pair value (sel[1] tens, sel[0] ones)
//   seg_out    : active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//   sel        : active-low one-hot digit enable
module seg_scan_bcd
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50_000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dat1,
  input  logic [7:0] dat2,
  output logic [7:0] seg_out,
  output logic [3:0] sel
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_cnt_nxt_c;
  logic [1:0]       dig_idx;
  logic [1:0]       dig_idx_nxt_c;
  logic             slot_wrap_c;
  logic             frame_start_c;

  conv_state_e      state;
  conv_state_e      state_nxt;
  logic             start_pending;
  logic             conv_start_c;
  logic             latch_c;
  logic             clr_pending_c;

  logic             done1;
  logic             done2;
  bcd_t             bcd1;
  bcd_t             bcd2;
  bcd_t             disp1;
  bcd_t             disp2;

  bcd_t             pair_c;
  logic [7:0]       seg_nxt_c;
  logic [3:0]       sel_nxt_c;

  // Slot counter and digit index; index steps on every slot wrap
  always_comb begin
    slot_wrap_c    = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    slot_cnt_nxt_c = slot_wrap_c ? '0 : slot_cnt + CNT_W'(1);
    dig_idx_nxt_c  = slot_wrap_c ? dig_idx + 2'd1 : dig_idx;
    frame_start_c  = (slot_cnt == '0) && (dig_idx == 2'd0);
  end

  // Converter FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Converter FSM next state and strobes
  always_comb begin
    state_nxt     = state;
    conv_start_c  = 1'b0;
    latch_c       = 1'b0;
    clr_pending_c = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start_c || start_pending) begin
          state_nxt     = LOAD;
          clr_pending_c = 1'b1;
        end
      end
      LOAD: begin
        conv_start_c = 1'b1;
        state_nxt    = SHIFT;
      end
      SHIFT: begin
        if (done1 && done2) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        latch_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both converters run in lockstep from the shadow copies they capture
  bin2bcd_seq u_conv1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start_c),
    .bin   (dat1),
    .done  (done1),
    .bcd   (bcd1)
  );

  bin2bcd_seq u_conv2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start_c),
    .bin   (dat2),
    .done  (done2),
    .bcd   (bcd2)
  );

  // Digit decode for the slot about to be displayed; cycle 0 is blanked
  always_comb begin
    pair_c    = dig_idx_nxt_c[1] ? disp2 : disp1;
    sel_nxt_c = SEL_NONE;
    seg_nxt_c = SEG_BLANK;
    if (slot_cnt_nxt_c != '0) begin
      sel_nxt_c = sel_code(dig_idx_nxt_c);
      if (pair_c.hund != 4'd0) begin
        seg_nxt_c = SEG_DASH;
      end else if (!dig_idx_nxt_c[0]) begin
        seg_nxt_c = (BLANK_LZ && (pair_c.tens == 4'd0)) ? SEG_BLANK
                                                         : seg_code(pair_c.tens);
      end else begin
        seg_nxt_c = seg_code(pair_c.ones);
      end
    end
  end

  // Scan counters, display registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt      <= '0;
      dig_idx       <= 2'd0;
      start_pending <= 1'b1;
      disp1         <= '0;
      disp2         <= '0;
      sel           <= SEL_NONE;
      seg_out       <= SEG_BLANK;
    end else begin
      slot_cnt <= slot_cnt_nxt_c;
      dig_idx  <= dig_idx_nxt_c;
      if (clr_pending_c) begin
        start_pending <= 1'b0;
      end
      if (latch_c) begin
        disp1 <= bcd1;
        disp2 <= bcd2;
      end
      sel     <= sel_nxt_c;
      seg_out <= seg_nxt_c;
    end
  end

endmodule
